// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch-address generator states and architectural vectors.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pcgen_state_t;

  localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'hBFC0_0380;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry redirect buffer holding a redirect that arrived while a fetch
// request was waiting for acceptance. A buffered exception is sticky: a later
// branch cannot overwrite it, while a later exception or branch replaces a
// buffered branch (latest wins).
module pc_redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_exc_wr,
  input  logic [WIDTH-1:0] i_exc_target,
  input  logic             i_br_wr,
  input  logic [WIDTH-1:0] i_br_target,
  input  logic             i_clr,
  output logic             o_pend,
  output logic [WIDTH-1:0] o_pend_pc
);

  logic             r_pend;
  logic             r_pend_exc;
  logic [WIDTH-1:0] r_pend_pc;

  // Capture / overwrite / consume the buffered redirect.
  always_ff @(posedge clk) begin
    // NOTE: all state here is clocked, so only non-blocking assignments are used;
    // blocking ones would make the update order depend on statement order.
    if (rst) begin
      // NOTE: the target register is reset too, so a discarded redirect never
      // leaks X or stale data after reset; cheap for a single entry.
      r_pend     <= 1'b0;
      r_pend_exc <= 1'b0;
      r_pend_pc  <= '0;
    end else if (i_exc_wr) begin
      r_pend     <= 1'b1;
      r_pend_exc <= 1'b1;
      r_pend_pc  <= i_exc_target;
    end else if (i_br_wr && !(r_pend && r_pend_exc)) begin
      r_pend     <= 1'b1;
      r_pend_exc <= 1'b0;
      r_pend_pc  <= i_br_target;
    end else if (i_clr) begin
      r_pend     <= 1'b0;
      r_pend_exc <= 1'b0;
    end
  end

  assign o_pend    = r_pend;
  assign o_pend_pc = r_pend_pc;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, drives the instruction-side
// request handshake and selects the next PC (exception, buffered redirect,
// branch, sequential). Redirects arriving mid-handshake are buffered so the
// presented address never changes before it is accepted.
// Optional feature macro PC_ALIGN_CHECK_EN: flag misaligned PCs on adel and
// block fetch; when undefined, every PC load is forced word-aligned.
module pc_gen
  import cpu_defs_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter int unsigned       INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_target,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             inst_addr_ok,
  output logic             inst_req,
  output logic [WIDTH-1:0] pc,
  output logic             fire,
  output logic             adel
);

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = '1;
`else
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
`endif

  pcgen_state_t     r_state;
  pcgen_state_t     w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_adel;
  logic             w_can_apply;
  logic             w_exc_wr;
  logic             w_br_wr;
  logic             w_clr;
  logic             w_pend;
  logic [WIDTH-1:0] w_pend_pc;

`ifdef PC_ALIGN_CHECK_EN
  assign w_adel = |r_pc[1:0];
`else
  assign w_adel = 1'b0;
`endif

  // Handshake: no request in BOOT, and none while stalled or misaligned.
  assign inst_req = (r_state != BOOT) & ~stall & ~w_adel;
  assign fire     = inst_req & inst_addr_ok;
  assign pc       = r_pc;
  assign adel     = w_adel;

  // A redirect may touch pc only when no request is left waiting this cycle.
  assign w_can_apply = ~inst_req | fire;
  assign w_exc_wr    = exc_valid & ~w_can_apply;
  assign w_br_wr     = br_valid & ~exc_valid & ~w_can_apply;
  assign w_clr       = w_can_apply & w_pend & (exc_valid | ~w_adel);

  pc_redirect_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_exc_wr     (w_exc_wr),
    .i_exc_target (exc_target),
    .i_br_wr      (w_br_wr),
    .i_br_target  (br_target),
    .i_clr        (w_clr),
    .o_pend       (w_pend),
    .o_pend_pc    (w_pend_pc)
  );

  // Next-PC selection by priority: exception, buffered, branch, sequential.
  always_comb begin
    // NOTE: default first so every path assigns w_pc_next and no latch is inferred.
    w_pc_next = r_pc;
    if (exc_valid) begin
      if (w_can_apply) w_pc_next = exc_target;
    end else if (w_pend) begin
      if (w_can_apply && !w_adel) w_pc_next = w_pend_pc;
    end else if (br_valid) begin
      if (w_can_apply && !w_adel) w_pc_next = br_target;
    end else if (fire) begin
      w_pc_next = r_pc + WIDTH'(INC);
    end
  end

  // Next state: HOLD mirrors "a redirect is buffered behind an unaccepted request".
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:  w_state_next = FETCH;
      FETCH: if (w_exc_wr || w_br_wr) w_state_next = HOLD;
      HOLD:  if (w_clr) w_state_next = FETCH;
      default: w_state_next = BOOT;
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_VEC & ALIGN_MASK;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next & ALIGN_MASK;
    end
  end

endmodule
